calc_port_scheduler: RTL and testbench

- Shares one calculator ALU between NPORTS requester ports; each port's interface matches the existing stimulus port (4-bit cmd, 2-bit tag, 32-bit data).
- Buffers one request per port and grants in round-robin order.
- Tracks outstanding {port,tag} pairs and rejects tag reuse.
- Routes each ALU response back to the originating port as out_resp/out_tag/out_data.

---
 rtl/calc_sched_pkg.sv | 19 +
 rtl/calc_rr_picker.sv | 39 +++
 rtl/calc_port_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_calc_port_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_sched_pkg.sv
// Shared constants and types for the calculator port scheduler.
// Response codes, field widths and the arbitration FSM state encoding.
package calc_sched_pkg;

    localparam int CMD_W = 4;
    localparam int TAG_W = 2;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ISSUE  = 2'd2,
        REJECT = 2'd3
    } sched_state_e;

endpackage

// File: rtl/calc_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr.
// Returns a one-hot grant (all zero when nothing is requested) and its index.
module calc_rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic [N-1:0]  rot;
    logic [PW-1:0] off;

    // rot[i] is the request i positions after the pointer; N is a power of two so the add wraps.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot[gi] = req[ptr + PW'(gi)];
    end

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
            end
        end
    end

    assign idx = ptr + off;

    always_comb begin
        gnt = '0;
        if (|rot) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/calc_port_scheduler.sv
// Shares one calculator ALU between NPORTS requester ports with round-robin grants and
// per-{port,tag} outstanding tracking. Define CALC_SCHED_STATS_EN to add per-port grant counters.
module calc_port_scheduler
    import calc_sched_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int PW     = $clog2(NPORTS),
    parameter int DW     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_valid,
    output logic [NPORTS-1:0]        req_ready,
    input  logic [NPORTS*CMD_W-1:0]  req_cmd,
    input  logic [NPORTS*TAG_W-1:0]  req_tag,
    input  logic [NPORTS*DW-1:0]     req_data1,
    input  logic [NPORTS*DW-1:0]     req_data2,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output logic [CMD_W-1:0]         alu_cmd,
    output logic [PW+1:0]            alu_tag,
    output logic [DW-1:0]            alu_data1,
    output logic [DW-1:0]            alu_data2,
    input  logic                     alu_resp_valid,
    input  logic [1:0]               alu_resp,
    input  logic [PW+1:0]            alu_resp_tag,
    input  logic [DW-1:0]            alu_resp_data,
    output logic [NPORTS*2-1:0]      out_resp,
    output logic [NPORTS*TAG_W-1:0]  out_tag,
    output logic [NPORTS*DW-1:0]     out_data,
    output logic                     err_spurious
`ifdef CALC_SCHED_STATS_EN
    ,
    output logic [NPORTS*16-1:0]     grant_count
`endif
);

    localparam int SBW = NPORTS * 4;

    sched_state_e                        state_q, state_d;
    logic [NPORTS-1:0]                   full_q, full_d;
    logic [NPORTS-1:0][CMD_W-1:0]        cmd_q, cmd_d;
    logic [NPORTS-1:0][TAG_W-1:0]        tag_q, tag_d;
    logic [NPORTS-1:0][DW-1:0]           d1_q, d1_d, d2_q, d2_d;
    logic [SBW-1:0]                      sb_q, sb_d;
    logic [PW-1:0]                       rr_q, rr_d, gnt_q, gnt_d;
    logic                                alu_valid_q, alu_valid_d;
    logic [CMD_W-1:0]                    alu_cmd_q, alu_cmd_d;
    logic [PW+1:0]                       alu_tag_q, alu_tag_d;
    logic [DW-1:0]                       alu_data1_q, alu_data1_d, alu_data2_q, alu_data2_d;
    logic [NPORTS-1:0][1:0]              out_resp_q, out_resp_d;
    logic [NPORTS-1:0][TAG_W-1:0]        out_tag_q, out_tag_d;
    logic [NPORTS-1:0][DW-1:0]           out_data_q, out_data_d;
    logic                                err_q, err_d;

    logic [NPORTS-1:0] pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic [PW+1:0]     arb_key;
    logic [PW-1:0]     resp_port;
    logic              resp_hit;
    logic              accept;
    logic              collide;

    calc_rr_picker #(.N(NPORTS), .PW(PW)) u_picker (
        .req (full_q),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign arb_key   = {pick_idx, tag_q[pick_idx]};
    assign resp_port = alu_resp_tag[PW+1:2];
    assign resp_hit  = alu_resp_valid && sb_q[alu_resp_tag];
    assign accept    = (state_q == ISSUE) && alu_ready;
    assign collide   = resp_hit && (resp_port == gnt_q);

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        cmd_d       = cmd_q;
        tag_d       = tag_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        sb_d        = sb_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        alu_valid_d = alu_valid_q;
        alu_cmd_d   = alu_cmd_q;
        alu_tag_d   = alu_tag_q;
        alu_data1_d = alu_data1_q;
        alu_data2_d = alu_data2_q;
        out_resp_d  = '0;
        out_tag_d   = '0;
        out_data_d  = '0;
        err_d       = err_q;

        for (int p = 0; p < NPORTS; p++) begin
            if (req_valid[p] && !full_q[p]) begin
                full_d[p] = 1'b1;
                cmd_d[p]  = req_cmd[p*CMD_W +: CMD_W];
                tag_d[p]  = req_tag[p*TAG_W +: TAG_W];
                d1_d[p]   = req_data1[p*DW +: DW];
                d2_d[p]   = req_data2[p*DW +: DW];
            end
        end

        if (resp_hit) begin
            sb_d[alu_resp_tag]    = 1'b0;
            out_resp_d[resp_port] = alu_resp;
            out_tag_d[resp_port]  = alu_resp_tag[1:0];
            out_data_d[resp_port] = alu_resp_data;
        end else if (alu_resp_valid) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|full_d) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (|pick_gnt) begin
                    gnt_d = pick_idx;
                    // A response retiring this exact {port,tag} this cycle counts as already free.
                    if (sb_q[arb_key] && !(resp_hit && alu_resp_tag == arb_key)) begin
                        state_d = REJECT;
                    end else begin
                        state_d     = ISSUE;
                        alu_valid_d = 1'b1;
                        alu_cmd_d   = cmd_q[pick_idx];
                        alu_tag_d   = arb_key;
                        alu_data1_d = d1_q[pick_idx];
                        alu_data2_d = d2_q[pick_idx];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (alu_ready) begin
                    alu_valid_d     = 1'b0;
                    sb_d[alu_tag_q] = 1'b1;
                    full_d[gnt_q]   = 1'b0;
                    rr_d            = gnt_q + PW'(1);
                    state_d         = (|full_d) ? ARB : IDLE;
                end
            end
            REJECT: begin
                // A response to the same port owns the outputs; the reject waits a cycle.
                if (!collide) begin
                    out_resp_d[gnt_q] = RESP_ERR;
                    out_tag_d[gnt_q]  = tag_q[gnt_q];
                    out_data_d[gnt_q] = '0;
                    full_d[gnt_q]     = 1'b0;
                    rr_d              = gnt_q + PW'(1);
                    state_d           = (|full_d) ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            full_q      <= '0;
            cmd_q       <= '0;
            tag_q       <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            sb_q        <= '0;
            rr_q        <= '0;
            gnt_q       <= '0;
            alu_valid_q <= 1'b0;
            alu_cmd_q   <= '0;
            alu_tag_q   <= '0;
            alu_data1_q <= '0;
            alu_data2_q <= '0;
            out_resp_q  <= '0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            cmd_q       <= cmd_d;
            tag_q       <= tag_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            sb_q        <= sb_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            alu_valid_q <= alu_valid_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_tag_q   <= alu_tag_d;
            alu_data1_q <= alu_data1_d;
            alu_data2_q <= alu_data2_d;
            out_resp_q  <= out_resp_d;
            out_tag_q   <= out_tag_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign alu_valid    = alu_valid_q;
    assign alu_cmd      = alu_cmd_q;
    assign alu_tag      = alu_tag_q;
    assign alu_data1    = alu_data1_q;
    assign alu_data2    = alu_data2_q;
    assign err_spurious = err_q;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        assign req_ready[gi]              = ~full_q[gi];
        assign out_resp[gi*2 +: 2]        = out_resp_q[gi];
        assign out_tag[gi*TAG_W +: TAG_W] = out_tag_q[gi];
        assign out_data[gi*DW +: DW]      = out_data_q[gi];
    end

`ifdef CALC_SCHED_STATS_EN
    logic [NPORTS-1:0][15:0] gcnt_q, gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        if (accept && gcnt_q[gnt_q] != 16'hFFFF) begin
            gcnt_d[gnt_q] = gcnt_q[gnt_q] + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_stats
        assign grant_count[gi*16 +: 16] = gcnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed self-checking bench for calc_port_scheduler: a vector table of single
// transactions followed by hand-written multi-cycle sequences.
module tb_calc_port_scheduler;
    import calc_sched_pkg::*;

    localparam int NPORTS = 4;
    localparam int PW     = 2;
    localparam int DW     = 32;

    logic                    clk;
    logic                    reset;
    logic [NPORTS-1:0]       req_valid;
    logic [NPORTS-1:0]       req_ready;
    logic [NPORTS*4-1:0]     req_cmd;
    logic [NPORTS*2-1:0]     req_tag;
    logic [NPORTS*DW-1:0]    req_data1;
    logic [NPORTS*DW-1:0]    req_data2;
    logic                    alu_valid;
    logic                    alu_ready;
    logic [3:0]              alu_cmd;
    logic [PW+1:0]           alu_tag;
    logic [DW-1:0]           alu_data1;
    logic [DW-1:0]           alu_data2;
    logic                    alu_resp_valid;
    logic [1:0]              alu_resp;
    logic [PW+1:0]           alu_resp_tag;
    logic [DW-1:0]           alu_resp_data;
    logic [NPORTS*2-1:0]     out_resp;
    logic [NPORTS*2-1:0]     out_tag;
    logic [NPORTS*DW-1:0]    out_data;
    logic                    err_spurious;
`ifdef CALC_SCHED_STATS_EN
    logic [NPORTS*16-1:0]    grant_count;
`endif

    int errors = 0;
    int checks = 0;

    calc_port_scheduler #(.NPORTS(NPORTS), .PW(PW), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmd        (req_cmd),
        .req_tag        (req_tag),
        .req_data1      (req_data1),
        .req_data2      (req_data2),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_cmd        (alu_cmd),
        .alu_tag        (alu_tag),
        .alu_data1      (alu_data1),
        .alu_data2      (alu_data2),
        .alu_resp_valid (alu_resp_valid),
        .alu_resp       (alu_resp),
        .alu_resp_tag   (alu_resp_tag),
        .alu_resp_data  (alu_resp_data),
        .out_resp       (out_resp),
        .out_tag        (out_tag),
        .out_data       (out_data),
        .err_spurious   (err_spurious)
`ifdef CALC_SCHED_STATS_EN
        ,
        .grant_count    (grant_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  resp;
        logic [31:0] res;
        logic [3:0]  exp_atag;
    } vec_t;

    vec_t       vecs[4];
    logic [1:0] gp[4];
    int         ng;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                        input logic [31:0] d1, input logic [31:0] d2);
        req_valid[p]           = 1'b1;
        req_cmd[p*4 +: 4]      = cmd;
        req_tag[p*2 +: 2]      = tag;
        req_data1[p*DW +: DW]  = d1;
        req_data2[p*DW +: DW]  = d2;
        tick();
        req_valid[p] = 1'b0;
    endtask

    task automatic respond(input logic [3:0] t, input logic [1:0] r, input logic [31:0] d);
        alu_resp_valid = 1'b1;
        alu_resp_tag   = t;
        alu_resp       = r;
        alu_resp_data  = d;
        tick();
        alu_resp_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (alu_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(alu_valid), 64'd1);
    endtask

    task automatic issue_one(input int p, input logic [1:0] tag);
        send(p, 4'd1, tag, 32'd1, 32'd2);
        wait_valid("issue_wait");
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
    endtask

    // All four ports request together with alu_ready held high; record grant order.
    task automatic round(input int start, input logic [1:0] tg);
        for (int p = 0; p < NPORTS; p++) begin
            req_valid[p]          = 1'b1;
            req_cmd[p*4 +: 4]     = 4'd2;
            req_tag[p*2 +: 2]     = tg;
            req_data1[p*DW +: DW] = 32'(p);
            req_data2[p*DW +: DW] = 32'd0;
        end
        tick();
        req_valid = '0;
        alu_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            if (alu_valid === 1'b1) begin
                gp[ng] = alu_tag[3:2];
                ng++;
            end
            tick();
        end
        alu_ready = 1'b0;
        check("rr_count", 64'(ng), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check("rr_order", 64'(gp[k]), 64'((start + k) % 4));
        end
        for (int p = 0; p < NPORTS; p++) begin
            respond({2'(p), tg}, RESP_OK, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{port: 0, cmd: 4'd1, tag: 2'd0, d1: 32'd5, d2: 32'd7,
                    resp: 2'b01, res: 32'd12, exp_atag: 4'h0};
        vecs[1] = '{port: 1, cmd: 4'd2, tag: 2'd1, d1: 32'd9, d2: 32'd4,
                    resp: 2'b01, res: 32'd5, exp_atag: 4'h5};
        vecs[2] = '{port: 2, cmd: 4'd1, tag: 2'd3, d1: 32'hFFFF_FFFF, d2: 32'd1,
                    resp: 2'b01, res: 32'd0, exp_atag: 4'hB};
        vecs[3] = '{port: 3, cmd: 4'd4, tag: 2'd2, d1: 32'd3, d2: 32'd3,
                    resp: 2'b10, res: 32'hDEAD_0001, exp_atag: 4'hE};

        reset          = 1'b1;
        req_valid      = '0;
        req_cmd        = '0;
        req_tag        = '0;
        req_data1      = '0;
        req_data2      = '0;
        alu_ready      = 1'b0;
        alu_resp_valid = 1'b0;
        alu_resp       = '0;
        alu_resp_tag   = '0;
        alu_resp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'hF);
        check("rst_alu_valid", 64'(alu_valid), 64'd0);
        check("rst_out_resp", 64'(out_resp), 64'd0);
        check("rst_err", 64'(err_spurious), 64'd0);
        check("rst_alu_tag", 64'(alu_tag), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            int p;
            p = vecs[i].port;
            send(p, vecs[i].cmd, vecs[i].tag, vecs[i].d1, vecs[i].d2);
            check("vec_ready_drop", 64'(req_ready[p]), 64'd0);
            check("vec_no_early_valid", 64'(alu_valid), 64'd0);
            tick();
            check("vec_alu_valid", 64'(alu_valid), 64'd1);
            check("vec_alu_tag", 64'(alu_tag), 64'(vecs[i].exp_atag));
            check("vec_alu_cmd", 64'(alu_cmd), 64'(vecs[i].cmd));
            check("vec_alu_d1", 64'(alu_data1), 64'(vecs[i].d1));
            check("vec_alu_d2", 64'(alu_data2), 64'(vecs[i].d2));
            alu_ready = 1'b1;
            tick();
            alu_ready = 1'b0;
            check("vec_alu_drop", 64'(alu_valid), 64'd0);
            check("vec_ready_back", 64'(req_ready[p]), 64'd1);
            respond(vecs[i].exp_atag, vecs[i].resp, vecs[i].res);
            check("vec_out_resp", 64'(out_resp[p*2 +: 2]), 64'(vecs[i].resp));
            check("vec_out_tag", 64'(out_tag[p*2 +: 2]), 64'(vecs[i].tag));
            check("vec_out_data", 64'(out_data[p*DW +: DW]), 64'(vecs[i].res));
            tick();
            check("vec_out_pulse", 64'(out_resp), 64'd0);
            $display("vec %0d port %0d atag %0h done", i, p, vecs[i].exp_atag);
        end

        round(0, 2'd0);
        issue_one(0, 2'd1);
        respond(4'h1, RESP_OK, 32'd0);
        round(1, 2'd1);
        $display("round robin sequences done");

        // Tag reuse on port 2 while {2,3} and {2,0} are outstanding.
        issue_one(2, 2'd3);
        issue_one(2, 2'd0);
        send(2, 4'd1, 2'd3, 32'd8, 32'd9);
        check("rej_no_valid1", 64'(alu_valid), 64'd0);
        tick();
        check("rej_no_valid2", 64'(alu_valid), 64'd0);
        check("rej_not_yet", 64'(out_resp), 64'd0);
        tick();
        check("rej_resp", 64'(out_resp[5:4]), 64'(RESP_ERR));
        check("rej_tag", 64'(out_tag[5:4]), 64'd3);
        check("rej_data", 64'(out_data[95:64]), 64'd0);
        check("rej_ready", 64'(req_ready[2]), 64'd1);
        check("rej_no_valid3", 64'(alu_valid), 64'd0);
        tick();
        check("rej_pulse", 64'(out_resp), 64'd0);
        $display("tag reuse reject done");

        // Response to port 2 lands in the reject cycle: response first, reject one cycle later.
        send(2, 4'd1, 2'd3, 32'd8, 32'd9);
        tick();
        respond(4'h8, RESP_OK, 32'd42);
        check("col_resp", 64'(out_resp[5:4]), 64'(RESP_OK));
        check("col_tag", 64'(out_tag[5:4]), 64'd0);
        check("col_data", 64'(out_data[95:64]), 64'd42);
        check("col_held", 64'(req_ready[2]), 64'd0);
        tick();
        check("col_rej_resp", 64'(out_resp[5:4]), 64'(RESP_ERR));
        check("col_rej_tag", 64'(out_tag[5:4]), 64'd3);
        tick();
        check("col_pulse", 64'(out_resp), 64'd0);
        $display("reject/response collision done");

        // Response clearing {2,3} during the ARB cycle lets the new request issue.
        send(2, 4'd6, 2'd3, 32'd11, 32'd12);
        respond(4'hB, RESP_OK, 32'd77);
        check("clr_issue", 64'(alu_valid), 64'd1);
        check("clr_atag", 64'(alu_tag), 64'hB);
        check("clr_resp", 64'(out_resp[5:4]), 64'(RESP_OK));
        check("clr_data", 64'(out_data[95:64]), 64'd77);
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        respond(4'hB, RESP_OK, 32'd1);
        $display("same-cycle clear done");

        // Backpressure: alu_ready low for five cycles.
        send(1, 4'd3, 2'd2, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 64'(alu_valid), 64'd1);
            check("bp_tag", 64'(alu_tag), 64'h6);
            check("bp_cmd", 64'(alu_cmd), 64'd3);
            check("bp_d1", 64'(alu_data1), 64'hA5A5_A5A5);
            check("bp_d2", 64'(alu_data2), 64'h5A5A_5A5A);
            check("bp_held", 64'(req_ready[1]), 64'd0);
            tick();
        end
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        check("bp_drop", 64'(alu_valid), 64'd0);
        check("bp_free", 64'(req_ready[1]), 64'd1);
        respond(4'h6, RESP_OK, 32'd3);
        $display("backpressure done");

        // Spurious response to {1,2}, which is no longer outstanding.
        check("sp_pre", 64'(err_spurious), 64'd0);
        respond(4'h6, RESP_OK, 32'd99);
        check("sp_no_out", 64'(out_resp), 64'd0);
        check("sp_err", 64'(err_spurious), 64'd1);
        repeat (3) tick();
        check("sp_sticky", 64'(err_spurious), 64'd1);
        $display("spurious response done");

        // Reset during ISSUE, then the late response arrives.
        send(3, 4'd5, 2'd1, 32'd4, 32'd4);
        tick();
        check("mid_valid", 64'(alu_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(alu_valid), 64'd0);
        check("mid_rst_err", 64'(err_spurious), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'hF);
        @(posedge clk);
        #1 reset = 1'b0;
        respond(4'hD, RESP_OK, 32'd8);
        check("late_no_out", 64'(out_resp), 64'd0);
        check("late_err", 64'(err_spurious), 64'd1);
        check("late_no_valid", 64'(alu_valid), 64'd0);
        $display("reset during issue done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
